// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential double-dabble binary-to-BCD converter.
// Holds the state encoding, counter sizing helper and BCD adjust constant.
package bin2bcd_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StShift = 2'd1;
  localparam state_t StDone  = 2'd2;

  localparam logic [3:0] BcdAdjust = 4'd3;

  // Bits needed to represent values 0 .. value-1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/bin2bcd_if.sv
// Handshake and data bundle between a requester and the binary-to-BCD converter.
interface bin2bcd_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) ();

  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;

  modport master (
    output start, bin,
    input  busy, done, bcd, overflow
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, overflow
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 (mod 16) to a BCD digit of 5 or more.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + BcdAdjust;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential WIDTH-cycle shift-and-add-3 binary-to-BCD converter with start/done
// handshake; results beyond DIGITS digits are truncated and flagged as overflow.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic        clk,
  input  logic        resetn,
  bin2bcd_if.slave    bus
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

  state_t            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [BcdW-1:0]   scratch_q, scratch_d;
  logic              ovf_scr_q, ovf_scr_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic              ovf_q, ovf_d;
  logic [BcdW-1:0]   adj_digits;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (scratch_q[4*g +: 4]),
      .digit_o (adj_digits[4*g +: 4])
    );
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    ovf_scr_d = ovf_scr_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d   = StShift;
          shift_d   = bus.bin;
          scratch_d = '0;
          cnt_d     = '0;
          ovf_scr_d = 1'b0;
        end else begin
          state_d   = StIdle;
        end
      end
      StShift: begin
        // The bit leaving the top digit is lost from the result but marks overflow.
        scratch_d = {adj_digits[BcdW-2:0], shift_q[WIDTH-1]};
        shift_d   = {shift_q[WIDTH-2:0], 1'b0};
        ovf_scr_d = ovf_scr_q | adj_digits[BcdW-1];
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LastIter) begin
          state_d = StDone;
          bcd_d   = scratch_d;
          ovf_d   = ovf_scr_d;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shift_q   <= '0;
      scratch_q <= '0;
      ovf_scr_q <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      ovf_scr_q <= ovf_scr_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.busy     = (state_q == StShift);
  assign bus.done     = (state_q == StDone);
  assign bus.bcd      = bcd_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq in three configurations (8/3, 8/2, 16/5),
// comparing against an arithmetic decimal-digit reference model.
module tb_bin2bcd_seq;

  logic clk;
  logic resetn;

  int          sel;
  logic        start_v;
  logic [15:0] bin_v;

  logic        done_m, busy_m, ovf_m;
  logic [19:0] bcd_m;

  int checks;
  int failures;

  bin2bcd_if #(.WIDTH(8),  .DIGITS(3)) if0 ();
  bin2bcd_if #(.WIDTH(8),  .DIGITS(2)) if1 ();
  bin2bcd_if #(.WIDTH(16), .DIGITS(5)) if2 ();

  bin2bcd_seq #(.WIDTH(8),  .DIGITS(3)) u_dut0 (.clk(clk), .resetn(resetn), .bus(if0));
  bin2bcd_seq #(.WIDTH(8),  .DIGITS(2)) u_dut1 (.clk(clk), .resetn(resetn), .bus(if1));
  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) u_dut2 (.clk(clk), .resetn(resetn), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    if0.start = start_v && (sel == 0);
    if1.start = start_v && (sel == 1);
    if2.start = start_v && (sel == 2);
    if0.bin   = bin_v[7:0];
    if1.bin   = bin_v[7:0];
    if2.bin   = bin_v;
  end

  always_comb begin
    done_m = 1'b0;
    busy_m = 1'b0;
    ovf_m  = 1'b0;
    bcd_m  = '0;
    case (sel)
      0: begin done_m = if0.done; busy_m = if0.busy; ovf_m = if0.overflow; bcd_m = 20'(if0.bcd); end
      1: begin done_m = if1.done; busy_m = if1.busy; ovf_m = if1.overflow; bcd_m = 20'(if1.bcd); end
      default: begin
        done_m = if2.done; busy_m = if2.busy; ovf_m = if2.overflow; bcd_m = if2.bcd;
      end
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // done and busy must never be high together in any instance.
  always @(negedge clk) begin
    if (resetn && (if0.done || if1.done || if2.done)) begin
      check("done_busy_excl", {29'd0, if0.done & if0.busy, if1.done & if1.busy,
                               if2.done & if2.busy}, 32'd0);
    end
  end

  function automatic int width_of(input int s);
    return (s == 2) ? 16 : 8;
  endfunction

  // Reference: decimal digits of bin mod 10^DIGITS, overflow if bin does not fit.
  task automatic model(input int s, input logic [15:0] b, output logic [19:0] e, output logic o);
    int digits;
    int modulus;
    int v;
    digits  = (s == 0) ? 3 : (s == 1) ? 2 : 5;
    modulus = 10 ** digits;
    v       = int'(b) % modulus;
    o       = (int'(b) >= modulus);
    e       = '0;
    for (int k = 0; k < digits; k++) begin
      e[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
  endtask

  task automatic convert(input int s, input logic [15:0] b, output logic [19:0] r,
                         output logic o, output int lat, output int busy_n);
    start_v = 1'b0;
    @(negedge clk);
    sel     = s;
    bin_v   = b;
    start_v = 1'b1;
    @(posedge clk);
    #1;
    start_v = 1'b0;
    busy_n  = busy_m ? 1 : 0;
    lat     = -1;
    r       = '0;
    o       = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done_m) begin
        lat = n;
        r   = bcd_m;
        o   = ovf_m;
        break;
      end
      if (busy_m) busy_n++;
    end
  endtask

  task automatic run_and_check(input int s, input logic [15:0] b, input logic [19:0] e,
                               input logic eo);
    logic [19:0] r;
    logic        o;
    int          lat, busy_n;
    convert(s, b, r, o, lat, busy_n);
    check($sformatf("latency cfg%0d bin=%0d", s, b), lat, width_of(s));
    check($sformatf("busy_cycles cfg%0d bin=%0d", s, b), busy_n, width_of(s));
    check($sformatf("bcd cfg%0d bin=%0d", s, b), {12'd0, r}, {12'd0, e});
    check($sformatf("overflow cfg%0d bin=%0d", s, b), {31'd0, o}, {31'd0, eo});
  endtask

  typedef struct {
    int          s;
    logic [15:0] b;
    logic [19:0] e;
    logic        eo;
  } vec_t;

  initial begin
    vec_t        vecs[10];
    logic [19:0] e, r1, r2;
    logic        eo;
    logic [15:0] b;
    int          first, second, ndone;

    checks   = 0;
    failures = 0;
    sel      = 0;
    start_v  = 1'b0;
    bin_v    = '0;
    resetn   = 1'b0;

    vecs[0] = '{0, 16'd0,     20'h00000, 1'b0};
    vecs[1] = '{0, 16'd255,   20'h00255, 1'b0};
    vecs[2] = '{1, 16'd199,   20'h00099, 1'b1};
    vecs[3] = '{1, 16'd42,    20'h00042, 1'b0};
    vecs[4] = '{2, 16'd65535, 20'h65535, 1'b0};
    vecs[5] = '{0, 16'd100,   20'h00100, 1'b0};
    vecs[6] = '{1, 16'd100,   20'h00000, 1'b1};
    vecs[7] = '{1, 16'd99,    20'h00099, 1'b0};
    vecs[8] = '{2, 16'd10000, 20'h10000, 1'b0};
    vecs[9] = '{0, 16'd9,     20'h00009, 1'b0};

    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check($sformatf("reset busy cfg%0d", s), {31'd0, busy_m}, 32'd0);
      check($sformatf("reset done cfg%0d", s), {31'd0, done_m}, 32'd0);
      check($sformatf("reset bcd cfg%0d", s), {12'd0, bcd_m}, 32'd0);
      check($sformatf("reset ovf cfg%0d", s), {31'd0, ovf_m}, 32'd0);
    end
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_and_check(vecs[i].s, vecs[i].b, vecs[i].e, vecs[i].eo);
    end

    for (int i = 0; i < 60; i++) begin
      int s;
      s = i % 3;
      b = (s == 2) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 255));
      model(s, b, e, eo);
      run_and_check(s, b, e, eo);
    end

    // Back-to-back with start held: bin changes mid-conversion, second accepted in DONE.
    start_v = 1'b0;
    @(negedge clk);
    sel     = 0;
    bin_v   = 16'd123;
    start_v = 1'b1;
    @(posedge clk);
    #1;
    first  = -1;
    second = -1;
    r1     = '0;
    r2     = '0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      #1;
      if (n == 3) bin_v = 16'd77;
      if (first > 0 && n == first + 1) start_v = 1'b0;
      if (done_m) begin
        if (first < 0) begin
          first = n;
          r1    = bcd_m;
        end else if (second < 0) begin
          second = n;
          r2     = bcd_m;
          break;
        end
      end
    end
    start_v = 1'b0;
    check("b2b first_done_edge", first, 8);
    check("b2b first_bcd", {12'd0, r1}, 32'h123);
    check("b2b second_done_edge", second, 17);
    check("b2b second_bcd", {12'd0, r2}, 32'h077);

    // Reset during the fourth SHIFT cycle.
    @(negedge clk);
    sel     = 0;
    bin_v   = 16'd200;
    start_v = 1'b1;
    @(posedge clk);
    #1;
    start_v = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("abort busy", {31'd0, busy_m}, 32'd0);
    check("abort done", {31'd0, done_m}, 32'd0);
    check("abort bcd", {12'd0, bcd_m}, 32'd0);
    check("abort ovf", {31'd0, ovf_m}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    ndone  = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk);
      #1;
      if (done_m) ndone++;
    end
    check("abort no_done", ndone, 0);
    run_and_check(0, 16'd100, 20'h00100, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Parametrised sequential binary-to-BCD converter using shift-and-add-3 (double dabble). It supersedes the fixed 4-bit tens/units correction logic: it converts a WIDTH-bit unsigned value into DIGITS packed BCD digits over WIDTH clock cycles, with a start/done handshake and overflow reporting. It sits between datapath registers and the seven-segment display decoders.

## Interface
- WIDTH, default 8: binary input width, minimum 4.
- DIGITS, default 3: number of BCD output digits, minimum 1.
- clk  input  1  rising-edge clock.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  request a conversion of bin; sampled only when the block is not busy.
- bin  input  WIDTH  unsigned binary operand; sampled on the accepting edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; bcd and overflow are valid and updated.
- bcd  output  4*DIGITS  packed result; digit 0 (units) is in bits [3:0], digit k is in bits [4k+3:4k].
- overflow  output  1  high when the last result did not fit in DIGITS digits.

## Operation
- The block has three states:
  - IDLE: waiting for start.
  - SHIFT: performing the WIDTH iterations.
  - DONE: one-cycle result state.
- State transitions:
  - IDLE, start=1 -> SHIFT. On this edge the shift register loads bin and the BCD scratch register, the iteration counter and the overflow scratch bit clear.
  - SHIFT: each edge runs one iteration. First, every scratch digit of 5 or more gets 3 added (modulo 16). Then the combined {scratch BCD, shift register} shifts left by one.
  - SHIFT, after the WIDTH-th iteration -> DONE. The bcd and overflow output registers load on that same edge.
  - DONE, start=1 -> SHIFT, with the load performed as described for IDLE.
  - DONE, start=0 -> IDLE.
- Overflow handling:
  - Any 1 shifted out of the top of digit DIGITS-1 sets the overflow scratch bit (sticky for that conversion).
  - On overflow, bcd holds bin mod 10^DIGITS, which is the natural truncated double-dabble result. It does not saturate.
- start is ignored while in SHIFT. No queueing.
- bcd and overflow hold their last values until the next entry into DONE.
- Every digit of bcd is always in the range 0–9.

## Timing
- Reset values: busy=0, done=0, bcd=all zero, overflow=0, state=IDLE, scratch registers zero.
- Reset asserted mid-conversion aborts immediately with all outputs at their reset values. No done is produced for the aborted operation.
- The accepting edge is a rising edge with start=1 in IDLE or DONE.
- busy rises in the cycle after the accepting edge and stays high for exactly WIDTH cycles.
- done is high for exactly one cycle, WIDTH edges after the accepting edge. In that cycle busy=0.
- Maximum throughput is one conversion per WIDTH+1 cycles, achieved by holding start high.
- done and busy are never high together.
- done is a registered output (derived from state), not combinational from start.

## Structure
- Package bin2bcd_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - a clog2 function for sizing the iteration counter (width clog2(WIDTH+1));
  - the constant 3 for the BCD adjust step.
- Sub-module bcd_digit_adj is combinational: 4-bit in, 4-bit out, adds 3 if the input is 5 or more. Instantiate DIGITS copies in a generate loop.
- The top module contains the FSM, the counter, the shift and scratch registers, and the output registers.

## Test plan
- Basic conversions, WIDTH=8, DIGITS=3, reset then start with bin=0. Requirements:
  - bin=0: done after 8 edges, bcd=12'h000, overflow=0.
  - bin=255: bcd=12'h255, overflow=0, busy high for exactly 8 cycles.
- Overflow, WIDTH=8, DIGITS=2:
  - bin=199 -> bcd=8'h99, overflow=1.
  - then bin=42 -> bcd=8'h42, overflow=0.
- Ignored start, WIDTH=8, DIGITS=3: bin=123 with start held high, and bin changed to 77 mid-conversion. Requirements:
  - the first done gives bcd=12'h123;
  - the back-to-back conversion is accepted in the DONE cycle and gives 12'h077 exactly 9 cycles later.
- Reset mid-operation: resetn low during the 4th SHIFT cycle. Requirements:
  - bcd=0, busy=0, done=0 immediately, and no done pulse follows;
  - a subsequent start with bin=100 gives 12'h100.
- Wide configuration, WIDTH=16, DIGITS=5:
  - bin=65535 -> bcd=20'h65535 after 16 edges;
  - randomized sweep checked against a reference model.
